vdma_wr_burst_master: RTL
=========================

Name: vdma_wr_burst_master

Overview:
Upstream feeder of the AXI4-to-DDR-native bridge: converts one video frame of pixel-stream beats into sequential AXI4 write bursts into the DDR frame buffer.
Buffers incoming beats in an internal FIFO and issues one burst at a time (AW, then all W, then B), matching the bridge's single-outstanding-burst execution.
Frame start/size/base come from the VDMA control logic.

Parameters:
ADDR_WIDTH, 27, DDR native address width (awaddr width)
DATA_WIDTH, 256, beat width; 256 or 512 only
BURST_LEN, 64, max beats per burst; 1..256
FIFO_DEPTH, 512, data FIFO beats; power of 2, >= 2*BURST_LEN
ADDR_STEP, 8, address increment per beat (DDR column units)

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  async active-low reset
frame_start  in  1  one-cycle pulse: latch frame_base/frame_beats, begin frame
frame_base  in  ADDR_WIDTH  frame start address
frame_beats  in  24  total beats in frame
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after final B handshake
in_vld / in_rdy / in_data  in/out/in  1/1/DATA_WIDTH  pixel-beat stream
axi_awaddr / axi_awlen  out  ADDR_WIDTH / 9  burst address; awlen = beat count (NOT count-1)
axi_awvalid / axi_awready  out/in  1/1  AW handshake
axi_wdata / axi_wlast  out  DATA_WIDTH / 1  write beat; last of burst
axi_wvalid / axi_wready  out/in  1/1  W handshake
axi_bvalid / axi_bready  in/out  1/1  B handshake (bresp ignored)

Behaviour:
- Reset (axi_resetn low, async): state IDLE, FIFO flushed; busy, frame_done, in_rdy, axi_awvalid, axi_wvalid, axi_wlast, axi_bready = 0; axi_awaddr, axi_awlen = 0.
- Counters: beats_in (beats accepted, 24b), beats_left (beats not yet bursted, 24b), wr_addr (ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH).
- in_rdy = busy && !fifo_full && beats_in < frame_beats_lat; extra beats after frame complete are back-pressured, never accepted.
- States: IDLE -> (frame_start) WAIT_DATA; frame_start with frame_beats==0 -> DONE directly, no AW.
- WAIT_DATA: cur_len = min(BURST_LEN, beats_left); when fifo_count >= cur_len -> AW, registering axi_awaddr=wr_addr, axi_awlen=cur_len, axi_awvalid=1 next cycle.
- AW: hold awvalid/addr/len stable until awready; on handshake -> W; wr_addr += cur_len*ADDR_STEP; beats_left -= cur_len.
- W: axi_wvalid = 1 (data guaranteed present); FIFO pops on wvalid&&wready; beat counter asserts wlast on beat cur_len-1; on last handshake -> B.
- B: axi_bready=1; on bvalid -> WAIT_DATA if beats_left>0, else DONE.
- DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- busy=1 from cycle after frame_start through DONE.
- frame_start while busy: ignored.
- Simultaneous FIFO push and pop allowed; fifo_count unchanged.
- Latency: first awvalid 2 cycles after the cur_len-th beat is accepted.

Optional Feature:
VDMA_WR_OVF_CNT_EN: defined -> adds output ovf_cnt[15:0], counting cycles with busy && in_vld && !in_rdy, saturating at 0xFFFF, cleared on frame_start and reset. Undefined -> port and logic absent, otherwise identical.

Decomposition:
- Package vdma_pkg: state enum WR_MST_STATE {IDLE, WAIT_DATA, AW, W, B, DONE}, FRAME_BEATS_W=24, AXI_LEN_W=9.
- Sub-module: vdma_sync_fifo (DATA_WIDTH x FIFO_DEPTH, show-ahead, count/full/empty outputs, async active-low reset).

Test Plan:
- frame_beats=128, BURST_LEN=64, base=0x100, continuous stream -> 2 bursts: awaddr 0x100/len 64, then 0x300/len 64; wlast on beats 64 and 128; one frame_done.
- frame_beats=100 -> bursts len 64 then 36; second awaddr = base+512; 100 W beats total.
- frame_beats=0 -> frame_done 2 cycles after start; no awvalid.
- awready delayed 5 cycles, wready toggled 50%, bvalid delayed 10 cycles -> awaddr/awlen stable while awvalid; no data lost or duplicated (scoreboard).
- in_vld held high past frame end, 40 extra beats -> in_rdy=0 after 128th beat; extras not written; frame_start during busy ignored.
- Assert axi_resetn low mid-W-burst -> all outputs at reset values immediately; new frame afterwards starts at its new frame_base with an empty FIFO.

Source files
------------

// File: rtl/vdma_pkg.sv
// rtl/vdma_pkg.sv - shared state type, widths and helpers for the VDMA write burst master
package vdma_pkg;

  localparam int FRAME_BEATS_W = 24;
  localparam int AXI_LEN_W     = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    AW,
    W,
    B,
    DONE
  } wr_mst_state_t;

  function automatic logic [FRAME_BEATS_W-1:0] min_beats(
    input logic [FRAME_BEATS_W-1:0] a,
    input logic [FRAME_BEATS_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/vdma_wr_burst_master_fifo.sv
// rtl/vdma_wr_burst_master_fifo.sv - show-ahead synchronous beat FIFO (vdma_sync_fifo)
module vdma_sync_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 512,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PTR_W:0]        count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vdma_wr_burst_master.sv
// rtl/vdma_wr_burst_master.sv - frame-to-AXI4 write burst master; VDMA_WR_OVF_CNT_EN adds ovf_cnt
module vdma_wr_burst_master
  import vdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_STEP  = 8
) (
  input  logic                     axi_aclk,
  input  logic                     axi_resetn,
  input  logic                     frame_start,
  input  logic [ADDR_WIDTH-1:0]    frame_base,
  input  logic [FRAME_BEATS_W-1:0] frame_beats,
  output logic                     busy,
  output logic                     frame_done,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic [ADDR_WIDTH-1:0]    axi_awaddr,
  output logic [AXI_LEN_W-1:0]     axi_awlen,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  output logic [DATA_WIDTH-1:0]    axi_wdata,
  output logic                     axi_wlast,
  output logic                     axi_wvalid,
  input  logic                     axi_wready,
  input  logic                     axi_bvalid,
  output logic                     axi_bready
`ifdef VDMA_WR_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FRAME_BEATS_W-1:0] BURST_MAX = FRAME_BEATS_W'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]    STEP      = ADDR_WIDTH'(ADDR_STEP);

  wr_mst_state_t            state;
  logic [FRAME_BEATS_W-1:0] frame_beats_lat;
  logic [FRAME_BEATS_W-1:0] beats_in;
  logic [FRAME_BEATS_W-1:0] beats_left;
  logic [FRAME_BEATS_W-1:0] cur_len;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [AXI_LEN_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     start_ok;

  assign cur_len  = min_beats(BURST_MAX, beats_left);
  assign in_rdy   = busy && !fifo_full && (beats_in < frame_beats_lat);
  assign push     = in_vld && in_rdy;
  assign pop      = axi_wvalid && axi_wready && !fifo_empty;
  assign start_ok = (state == IDLE) && frame_start;

  vdma_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (axi_aclk),
    .rst_n    (axi_resetn),
    .push     (push),
    .push_data(in_data),
    .pop      (pop),
    .rd_data  (axi_wdata),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn)   beats_in <= '0;
    else if (start_ok) beats_in <= '0;
    else if (push)     beats_in <= beats_in + 1'b1;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state           <= IDLE;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      axi_awvalid     <= 1'b0;
      axi_wvalid      <= 1'b0;
      axi_wlast       <= 1'b0;
      axi_bready      <= 1'b0;
      axi_awaddr      <= '0;
      axi_awlen       <= '0;
      frame_beats_lat <= '0;
      beats_left      <= '0;
      wr_addr         <= '0;
      beat_cnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            busy            <= 1'b1;
            frame_beats_lat <= frame_beats;
            beats_left      <= frame_beats;
            wr_addr         <= frame_base;
            state           <= (frame_beats == '0) ? DONE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // Whole burst must be buffered so W never stalls on an empty FIFO.
          if (FRAME_BEATS_W'(fifo_count) >= cur_len) begin
            axi_awaddr  <= wr_addr;
            axi_awlen   <= AXI_LEN_W'(cur_len);
            axi_awvalid <= 1'b1;
            state       <= AW;
          end
        end
        AW: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            wr_addr     <= wr_addr + ADDR_WIDTH'(axi_awlen) * STEP;
            beats_left  <= beats_left - FRAME_BEATS_W'(axi_awlen);
            axi_wvalid  <= 1'b1;
            axi_wlast   <= (axi_awlen == AXI_LEN_W'(1));
            beat_cnt    <= '0;
            state       <= W;
          end
        end
        W: begin
          if (axi_wready) begin
            beat_cnt  <= beat_cnt + 1'b1;
            axi_wlast <= (beat_cnt + AXI_LEN_W'(2) == axi_awlen);
            if (axi_wlast) begin
              axi_wvalid <= 1'b0;
              axi_wlast  <= 1'b0;
              axi_bready <= 1'b1;
              state      <= B;
            end
          end
        end
        B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            state      <= (beats_left != '0) ? WAIT_DATA : DONE;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VDMA_WR_OVF_CNT_EN
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn)   ovf_cnt <= '0;
    else if (start_ok) ovf_cnt <= '0;
    else if (busy && in_vld && !in_rdy && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
  end
`endif

endmodule
